// File: rtl/shift_unit_seq_pkg.sv
// globals: shared word length, shift opcodes and shift FSM state encoding.
package globals;
    localparam int WORDLEN = 16;

    typedef enum logic [2:0] {
        NIL = 3'd0,
        SHL = 3'd1,
        SHR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        SLA = 3'd5,
        SRA = 3'd6
    } shft_op_t;

    typedef logic [1:0] shft_state_t;
    localparam shft_state_t ST_IDLE = 2'd0;
    localparam shft_state_t ST_BUSY = 2'd1;
    localparam shft_state_t ST_DONE = 2'd2;
endpackage

// File: rtl/shift_unit_seq_step.sv
// shift_step: combinational shift/rotate by 1..STEP positions; sign-change output only with SHFT_OVF_EN.
module shift_step
    import globals::*;
#(
    parameter int WIDTH = 16,
    parameter int STEP  = 4,
    localparam int NW   = $clog2(STEP + 1)
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [NW-1:0]    i_n,
`ifdef SHFT_OVF_EN
    output logic             o_sign_chg,
`endif
    output logic [WIDTH-1:0] o_data,
    output logic             o_last
);
    logic [WIDTH-1:0] w_lsh, w_rsh, w_ash, w_rol, w_ror, w_hi, w_lo;
    assign w_lsh = i_data << i_n;
    assign w_rsh = i_data >> i_n;
    assign w_ash = $signed(i_data) >>> i_n;
    assign w_rol = w_lsh | (i_data >> (WIDTH - int'(i_n)));
    assign w_ror = w_rsh | (i_data << (WIDTH - int'(i_n)));
    // the last bit to leave is the edge bit after shifting one position less
    assign w_hi  = i_data << (int'(i_n) - 1);
    assign w_lo  = i_data >> (int'(i_n) - 1);
    assign o_data = (i_op == SHL || i_op == SLA) ? w_lsh :
                    (i_op == SHR) ? w_rsh :
                    (i_op == SRA) ? w_ash :
                    (i_op == ROL) ? w_rol :
                    (i_op == ROR) ? w_ror : '0;
    assign o_last = (i_op == SHL || i_op == SLA) ? w_hi[WIDTH-1] :
                    (i_op == SHR || i_op == SRA) ? w_lo[0] :
                    (i_op == ROL) ? w_rol[0] :
                    (i_op == ROR) ? w_ror[WIDTH-1] : 1'b0;
`ifdef SHFT_OVF_EN
    logic [WIDTH-1:0] w_sh_k;
    always_comb begin
        o_sign_chg = 1'b0;
        w_sh_k     = '0;
        for (int k = 1; k <= STEP; k++) begin
            w_sh_k = i_data << k;
            if (i_op == SLA && k <= int'(i_n) && w_sh_k[WIDTH-1] != i_data[WIDTH-1]) o_sign_chg = 1'b1;
        end
    end
`endif
endmodule

// File: rtl/shift_unit_seq.sv
// shift_unit_seq: multi-cycle shifter/rotator, STEP bits per cycle, valid/ready on both sides.
// Define SHFT_OVF_EN to add the out_ovf port and SLA overflow tracking.
module shift_unit_seq
    import globals::*;
#(
    parameter int WIDTH    = 16,
    parameter int STEP     = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_amt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
`ifdef SHFT_OVF_EN
    output logic               out_ovf,
`endif
    output logic               out_carry
);
    localparam int NW = $clog2(STEP + 1);

    shft_state_t        r_state;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_rem;
    logic               r_carry, r_zero;
    logic [NW-1:0]      w_n;
    logic [WIDTH-1:0]   w_step_data;
    logic               w_last, w_inv, w_imm;

    assign w_n   = (int'(r_rem) > STEP) ? NW'(STEP) : NW'(r_rem);
    assign w_inv = (in_op == 3'd7);
    assign w_imm = w_inv || (in_op == NIL) || (in_amt == '0);

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_data;
    assign out_carry = r_carry;
    assign out_zero  = r_zero;

`ifdef SHFT_OVF_EN
    logic r_ovf, w_chg;
    assign out_ovf = r_ovf;
    shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .i_op(r_op), .i_data(r_data), .i_n(w_n),
        .o_sign_chg(w_chg), .o_data(w_step_data), .o_last(w_last)
    );
    always_ff @(posedge clk) begin
        if (rst) r_ovf <= 1'b0;
        else if (in_valid && in_ready) r_ovf <= 1'b0;
        else if (r_state == ST_BUSY) r_ovf <= r_ovf | w_chg;
    end
`else
    shift_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
        .i_op(r_op), .i_data(r_data), .i_n(w_n),
        .o_data(w_step_data), .o_last(w_last)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (in_valid) begin
                r_op    <= in_op;
                r_rem   <= in_amt;
                r_data  <= w_inv ? '0 : in_data;
                r_carry <= 1'b0;
                r_zero  <= w_inv || (in_data == '0);
                r_state <= w_imm ? ST_DONE : ST_BUSY;
            end
        end else if (r_state == ST_BUSY) begin
            r_data  <= w_step_data;
            r_carry <= w_last;
            r_zero  <= (w_step_data == '0);
            r_rem   <= r_rem - SHAMT_W'(w_n);
            if (int'(r_rem) <= STEP) r_state <= ST_DONE;
        end else if (out_ready) begin
            r_state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_shift_unit_seq.sv
// tb_shift_unit_seq: directed and randomized checks of shift_unit_seq against an arithmetic model.
// Define SHFT_OVF_EN to also check out_ovf.
module tb_shift_unit_seq;
    localparam int W = 16;
    localparam int S = 4;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
    logic [2:0]   in_op = '0;
    logic [W-1:0] in_data = '0;
    logic [3:0]   in_amt = '0;
    logic         in_ready, out_valid, out_zero, out_carry;
    logic [W-1:0] out_data;
`ifdef SHFT_OVF_EN
    logic         out_ovf;
`endif

    shift_unit_seq #(.WIDTH(W), .STEP(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero),
`ifdef SHFT_OVF_EN
        .out_ovf(out_ovf),
`endif
        .out_carry(out_carry)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [W-1:0] exp_data, got_data;
    logic exp_carry, exp_zero, exp_ovf, got_carry, got_zero, got_ovf;
    logic exp_armed = 1'b0;
    int   got_lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [W-1:0] d, input int a,
                                  output logic [W-1:0] r, output logic c, output logic o);
        logic [2*W-1:0] dd;
        dd = {d, d};
        r = '0; c = 1'b0; o = 1'b0;
        case (op)
            3'd0: r = d;
            3'd1, 3'd5: begin r = d << a; if (a > 0) c = d[W-a]; end
            3'd2: begin r = d >> a; if (a > 0) c = d[a-1]; end
            3'd6: begin r = W'($signed(d) >>> a); if (a > 0) c = d[a-1]; end
            3'd3: begin dd = dd << a; r = dd[2*W-1:W]; if (a > 0) c = r[0]; end
            3'd4: begin dd = dd >> a; r = dd[W-1:0]; if (a > 0) c = r[W-1]; end
            default: r = '0;
        endcase
        if (op == 3'd5)
            for (int k = 1; k <= a; k++) if (d[W-1-k] != d[W-1]) o = 1'b1;
    endfunction

    // Every cycle with a result on offer must show the modelled result and in_ready low.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!exp_armed) chk("stray_valid", out_valid, 0);
            else begin
                chk("data", out_data, exp_data);
                chk("carry", out_carry, exp_carry);
                chk("zero", out_zero, exp_zero);
`ifdef SHFT_OVF_EN
                chk("ovf", out_ovf, exp_ovf);
`endif
                chk("in_ready_done", in_ready, 0);
            end
        end
    end

    task automatic op_run(input logic [2:0] op, input logic [W-1:0] d, input int a, input int hold);
        logic [W-1:0] r;
        logic c, o;
        int lat;
        model(op, d, a, r, c, o);
        exp_data = r; exp_carry = c; exp_zero = (r == '0); exp_ovf = o; exp_armed = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        in_op = op; in_data = d; in_amt = 4'(a); in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin @(posedge clk); #1 lat++; end
        chk("latency", lat, (a == 0 || op == 3'd0 || op == 3'd7) ? 1 : 1 + (a + S - 1) / S);
        got_lat = lat; got_data = out_data; got_carry = out_carry; got_zero = out_zero;
`ifdef SHFT_OVF_EN
        got_ovf = out_ovf;
`else
        got_ovf = 1'b0;
`endif
        repeat (hold) begin @(posedge clk); #1; end
        if (hold > 0) chk("held_valid", out_valid, 1);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        exp_armed = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic lit(input string nm, input logic [2:0] op, input logic [W-1:0] d, input int a, input int hold,
                       input logic [W-1:0] e_data, input logic e_carry, input logic e_zero, input int e_lat,
                       input logic e_ovf);
        logic [W-1:0] r;
        logic c, o;
        model(op, d, a, r, c, o);
        chk({nm, "_model"}, {r, c}, {e_data, e_carry});
        op_run(op, d, a, hold);
        chk({nm, "_data"}, got_data, e_data);
        chk({nm, "_carry"}, got_carry, e_carry);
        chk({nm, "_zero"}, got_zero, e_zero);
        chk({nm, "_lat"}, got_lat, e_lat);
`ifdef SHFT_OVF_EN
        chk({nm, "_ovf"}, got_ovf, e_ovf);
`else
        if (e_ovf) chk({nm, "_ovf_model"}, o, e_ovf);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_carry", out_carry, 0);
        chk("rst_ready", in_ready, 1);
`ifdef SHFT_OVF_EN
        chk("rst_ovf", out_ovf, 0);
`endif
        lit("shl1",   3'd1, 16'h8001, 1, 0, 16'h0002, 1'b1, 1'b0, 2, 1'b0);
        lit("sra15",  3'd6, 16'h8000, 15, 0, 16'hFFFF, 1'b0, 1'b0, 5, 1'b0);
        lit("ror4",   3'd4, 16'h0008, 4, 0, 16'h8000, 1'b1, 1'b0, 2, 1'b0);
        lit("shr1",   3'd2, 16'h0001, 1, 0, 16'h0000, 1'b1, 1'b1, 2, 1'b0);
        lit("hold3",  3'd3, 16'h8001, 5, 3, 16'h0030, 1'b0, 1'b0, 3, 1'b0);
        lit("inval",  3'd7, 16'h1234, 3, 0, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        lit("nil0",   3'd0, 16'h0000, 6, 0, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        lit("amt0",   3'd1, 16'hA5A5, 0, 0, 16'hA5A5, 1'b0, 1'b0, 1, 1'b0);
        lit("sla_ov", 3'd5, 16'h4000, 1, 0, 16'h8000, 1'b0, 1'b0, 2, 1'b1);
        lit("sla_ok", 3'd5, 16'h2000, 1, 0, 16'h4000, 1'b0, 1'b0, 2, 1'b0);
        // Abandon an SHL by 12 while it is still shifting.
        in_op = 3'd1; in_data = 16'hFFFF; in_amt = 4'd12; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        repeat (8) begin @(posedge clk); #1; end
        chk("midrst_quiet", out_valid, 0);
        for (int i = 0; i < 300; i++)
            op_run(3'($urandom_range(0, 7)), W'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
